// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the MULT/DIV sequencer:
// ALU opcodes, HI/LO operation encodings and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIX1  = 3'd4,
    ST_FIX2  = 3'd5,
    ST_DONE  = 3'd6
  } md_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: borrows the shared ALU for one add/sub per
// cycle (shift-add multiply, restoring divide) and writes HI/LO on completion.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_carry
);

  md_state_t        state;
  logic [1:0]       op_r;
  logic             sign_a, sign_b, lo_zero;
  logic [WIDTH-1:0] acc, q, mag_b, fix1_r;
  logic [5:0]       cnt;

  logic             is_signed, is_div, neg_lo, neg_hi, qb;
  logic [WIDTH-1:0] div_t;

  assign is_signed = ~op_r[0];
  assign is_div    = op_r[1];
  assign neg_lo    = is_signed & (sign_a ^ sign_b);
  assign neg_hi    = is_div ? (is_signed & sign_a) : neg_lo;
  // Partial remainder is 33 bits wide: acc[MSB] is the bit shifted out of t.
  assign div_t     = {acc[WIDTH-2:0], q[WIDTH-1]};
  assign qb        = acc[WIDTH-1] | ~alu_carry;

  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign alu_req = busy;

  always_comb begin
    alu_aluc = ALU_ADDU;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      ST_ABS_A: begin
        if (is_signed && sign_a) begin
          alu_aluc = ALU_SUBU;
          alu_b    = q;
        end else begin
          alu_a = q;
        end
      end
      ST_ABS_B: begin
        if (is_signed && sign_b) begin
          alu_aluc = ALU_SUBU;
          alu_b    = mag_b;
        end else begin
          alu_a = mag_b;
        end
      end
      ST_ITER: begin
        if (is_div) begin
          alu_aluc = ALU_SUBU;
          alu_a    = div_t;
          alu_b    = mag_b;
        end else begin
          alu_a = acc;
          alu_b = q[0] ? mag_b : '0;
        end
      end
      ST_FIX1: begin
        if (neg_lo) begin
          alu_aluc = ALU_SUBU;
          alu_b    = q;
        end else begin
          alu_a = q;
        end
      end
      ST_FIX2: begin
        // Product high word negates as ~acc plus the carry out of the low word.
        if (neg_hi && is_div) begin
          alu_aluc = ALU_SUBU;
          alu_b    = acc;
        end else if (neg_hi) begin
          alu_a = ~acc;
          alu_b = {{(WIDTH-1){1'b0}}, lo_zero};
        end else begin
          alu_a = acc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_r        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      lo_zero     <= 1'b0;
      acc         <= '0;
      q           <= '0;
      mag_b       <= '0;
      fix1_r      <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            op_r        <= op;
            q           <= a;
            mag_b       <= b;
            sign_a      <= a[WIDTH-1];
            sign_b      <= b[WIDTH-1];
            div_by_zero <= 1'b0;
            if (op[1] && (b == '0)) begin
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_ABS_A;
            end
          end
        end
        ST_ABS_A: begin
          q     <= alu_r;
          acc   <= '0;
          state <= ST_ABS_B;
        end
        ST_ABS_B: begin
          mag_b <= alu_r;
          cnt   <= '0;
          state <= ST_ITER;
        end
        ST_ITER: begin
          cnt <= cnt + 6'd1;
          if (is_div) begin
            acc <= qb ? alu_r : div_t;
            q   <= {q[WIDTH-2:0], qb};
          end else begin
            acc <= {alu_carry, alu_r[WIDTH-1:1]};
            q   <= {alu_r[0], q[WIDTH-1:1]};
          end
          if (cnt == 6'(WIDTH - 1)) state <= ST_FIX1;
        end
        ST_FIX1: begin
          fix1_r  <= alu_r;
          lo_zero <= (q == '0);
          state   <= ST_FIX2;
        end
        ST_FIX2: begin
          hi    <= alu_r;
          lo    <= fix1_r;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural model of the shared ALU.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy, done, div_by_zero, alu_req, alu_carry;
  logic [31:0] hi, lo, alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic [32:0] alu_wide;

  int nchecks = 0;
  int npass = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Combinational ALU: bit 32 is carry for Addu, borrow for Subu.
  always_comb begin
    alu_wide = '0;
    case (alu_aluc)
      ALU_ADDU: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUBU: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_NOR:  alu_wide = {1'b0, ~(alu_a | alu_b)};
      default:  alu_wide = '0;
    endcase
  end
  assign alu_r     = alu_wide[31:0];
  assign alu_carry = alu_wide[32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz, input logic inject);
    int cyc;
    logic busy_seen;
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0; a_i = ~a; b_i = ~b;
    cyc = 1;
    check({name, "_busy_c1"}, 64'(busy), 64'(!exp_dbz));
    busy_seen = busy;
    while (!done && cyc < 60) begin
      if (inject && cyc == 10) begin
        start = 1'b1; op_i = 2'b11; a_i = 32'h1234_5678; b_i = 32'h0000_0003;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      busy_seen = busy_seen | busy;
      if (cyc == 36) begin
        check({name, "_hi_hold"}, 64'(hi), 64'(last_hi));
        check({name, "_lo_hold"}, 64'(lo), 64'(last_lo));
      end
    end
    check({name, "_latency"}, 64'(cyc), exp_dbz ? 64'd1 : 64'd37);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    check({name, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    check({name, "_busy_done"}, 64'(busy), 64'd0);
    if (exp_dbz) check({name, "_busy_never"}, 64'(busy_seen), 64'd0);
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  initial begin
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_alu_req", 64'(alu_req), 64'd0);
    check("rst_alu_idle", {28'd0, alu_aluc, alu_a}, 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("idle_done_low", 64'(done), 64'd0);
    check("idle_alu_zero", {28'd0, alu_aluc, alu_a}, 64'd0);
    run_op("mult_minsq", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("divu_max_1", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_7_neg2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_min_neg1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div_5_0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("divu_after_dbz", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    start = 1'b1; op_i = MD_MULT; a_i = 32'd1000; b_i = 32'hFFFF_FF00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_alu_req", 64'(alu_req), 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    last_hi = '0; last_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu_after_rst", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
